// File: rtl/trapez_peak_sampler_pkg.sv
// Shared widths, FSM state encoding and the pulse-height event record for
// the trapezoidal peak sampler.
package package_settings;

  localparam int SIZE_SHAPER_DATA = 16;
  localparam int SIZE_TIMESTAMP   = 32;
  localparam int SIZE_PHA_CNT     = 12;
  localparam int SIZE_LOST_CNT    = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WINDOW  = 2'd1,
    TAIL    = 2'd2,
    HOLDOFF = 2'd3
  } pha_state_t;

  typedef struct packed {
    logic signed [SIZE_SHAPER_DATA-1:0] height;
    logic [SIZE_TIMESTAMP-1:0]          timestamp;
    logic                               pileup;
  } pha_event_t;

endpackage

// File: rtl/trapez_peak_sampler_if.sv
// Valid/ready event channel from the peak sampler to the histogram/readout stage.
interface trapez_peak_sampler_if;
  import package_settings::*;

  logic                               event_valid;
  logic                               event_ready;
  logic signed [SIZE_SHAPER_DATA-1:0] event_height;
  logic [SIZE_TIMESTAMP-1:0]          event_timestamp;
  logic                               event_pileup;

  modport master (
    output event_valid,
    output event_height,
    output event_timestamp,
    output event_pileup,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  event_height,
    input  event_timestamp,
    input  event_pileup,
    output event_ready
  );

endinterface

// File: rtl/trapez_peak_sampler_pha_event_reg.sv
// One-deep output register for pulse-height events: loads when empty or being
// drained, otherwise drops the offer and bumps a saturating lost counter.
module pha_event_reg
  import package_settings::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     offer_i,
  input  pha_event_t               cand_i,
  input  logic                     pile_i,
  input  logic                     ready_i,
  output logic                     valid_o,
  output pha_event_t               event_o,
  output logic [SIZE_LOST_CNT-1:0] lost_o
);

  logic                     valid_q, valid_d;
  logic                     own_q, own_d;
  pha_event_t               event_q, event_d;
  logic [SIZE_LOST_CNT-1:0] lost_q, lost_d;

  // own_q marks that the held event belongs to the pulse whose tail is still
  // being watched, so a late pile-up may still be folded into it.
  always_comb begin
    valid_d = valid_q;
    own_d   = own_q;
    event_d = event_q;
    lost_d  = lost_q;
    if (offer_i) begin
      if (!valid_q || ready_i) begin
        event_d        = cand_i;
        event_d.pileup = cand_i.pileup | pile_i;
        valid_d        = 1'b1;
        own_d          = 1'b1;
      end else begin
        own_d = 1'b0;
        if (lost_q != '1) begin
          lost_d = lost_q + 1'b1;
        end
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
      own_d   = 1'b0;
    end else if (pile_i && own_q && valid_q) begin
      event_d.pileup = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      own_q   <= 1'b0;
      event_q <= '0;
      lost_q  <= '0;
    end else begin
      valid_q <= valid_d;
      own_q   <= own_d;
      event_q <= event_d;
      lost_q  <= lost_d;
    end
  end

  assign valid_o = valid_q;
  assign event_o = event_q;
  assign lost_o  = lost_q;

endmodule

// File: rtl/trapez_peak_sampler.sv
// Threshold-triggered peak sampler for trapezoidal shaper output: tracks the
// flat-top maximum, watches the tail for pile-up and issues one event per pulse.
module trapez_peak_sampler
  import package_settings::*;
(
  input  logic                               clk,
  input  logic                               reset,
  input  logic signed [SIZE_SHAPER_DATA-1:0] shaper_data,
  input  logic                               enable,
  input  logic signed [SIZE_SHAPER_DATA-1:0] threshold,
  input  logic [SIZE_PHA_CNT-1:0]            flat_top_delay,
  input  logic [SIZE_PHA_CNT-1:0]            holdoff,
  trapez_peak_sampler_if.master              evt,
  output logic                               busy,
  output logic [SIZE_LOST_CNT-1:0]           lost_count
);

  pha_state_t                         state_q, state_d;
  logic [SIZE_PHA_CNT-1:0]            cnt_q, cnt_d;
  logic signed [SIZE_SHAPER_DATA-1:0] max_q, max_d;
  logic signed [SIZE_SHAPER_DATA-1:0] thr_q, thr_d;
  logic [SIZE_TIMESTAMP-1:0]          ts_q;
  logic [SIZE_TIMESTAMP-1:0]          ts_lat_q, ts_lat_d;
  logic                               offer_q, offer_d;
  pha_event_t                         cand_q, cand_d;
  logic signed [SIZE_SHAPER_DATA-1:0] window_max;
  logic                               pile;
  pha_event_t                         evt_out;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    max_d      = max_q;
    thr_d      = thr_q;
    ts_lat_d   = ts_lat_q;
    offer_d    = 1'b0;
    cand_d     = cand_q;
    pile       = 1'b0;
    window_max = (shaper_data > max_q) ? shaper_data : max_q;
    unique case (state_q)
      IDLE: begin
        if (enable && (shaper_data > threshold)) begin
          ts_lat_d = ts_q;
          max_d    = shaper_data;
          thr_d    = threshold;
          // The crossing sample is the first of the flat_top_delay+1 window samples.
          if (flat_top_delay == '0) begin
            offer_d          = 1'b1;
            cand_d.height    = shaper_data;
            cand_d.timestamp = ts_q;
            cand_d.pileup    = 1'b0;
            state_d          = TAIL;
          end else begin
            cnt_d   = flat_top_delay - SIZE_PHA_CNT'(1);
            state_d = WINDOW;
          end
        end
      end
      WINDOW: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          max_d = window_max;
          if (cnt_q == '0) begin
            offer_d          = 1'b1;
            cand_d.height    = window_max;
            cand_d.timestamp = ts_lat_q;
            cand_d.pileup    = 1'b0;
            state_d          = TAIL;
          end else begin
            cnt_d = cnt_q - SIZE_PHA_CNT'(1);
          end
        end
      end
      TAIL: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          pile = (shaper_data > max_q);
          if (shaper_data <= thr_q) begin
            if (holdoff == '0) begin
              state_d = IDLE;
            end else begin
              cnt_d   = holdoff;
              state_d = HOLDOFF;
            end
          end
        end
      end
      HOLDOFF: begin
        // Exactly holdoff dead cycles before crossings are honoured again.
        cnt_d = cnt_q - SIZE_PHA_CNT'(1);
        if (!enable || (cnt_q == SIZE_PHA_CNT'(1))) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      max_q    <= '0;
      thr_q    <= '0;
      ts_q     <= '0;
      ts_lat_q <= '0;
      offer_q  <= 1'b0;
      cand_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      max_q    <= max_d;
      thr_q    <= thr_d;
      ts_q     <= ts_q + 1'b1;
      ts_lat_q <= ts_lat_d;
      offer_q  <= offer_d;
      cand_q   <= cand_d;
    end
  end

  pha_event_reg u_event_reg (
    .clk     (clk),
    .reset   (reset),
    .offer_i (offer_q),
    .cand_i  (cand_q),
    .pile_i  (pile),
    .ready_i (evt.event_ready),
    .valid_o (evt.event_valid),
    .event_o (evt_out),
    .lost_o  (lost_count)
  );

  assign evt.event_height    = evt_out.height;
  assign evt.event_timestamp = evt_out.timestamp;
  assign evt.event_pileup    = evt_out.pileup;
  assign busy                = (state_q != IDLE);

endmodule

// File: tb/tb_trapez_peak_sampler.sv
// Scoreboard bench for trapez_peak_sampler: a pulse-level reference model
// predicts accepted events; a monitor compares them as the DUT hands them over.
module tb_trapez_peak_sampler;
  import package_settings::*;

  typedef struct {
    int height;
    int ts;
    bit pile;
    int cyc;
  } exp_t;

  logic                               clk = 1'b0;
  logic                               rst_n = 1'b0;
  logic                               enable = 1'b0;
  logic                               ready = 1'b0;
  logic signed [SIZE_SHAPER_DATA-1:0] data = '0;
  logic signed [SIZE_SHAPER_DATA-1:0] thr = '0;
  logic [SIZE_PHA_CNT-1:0]            ftd = '0;
  logic [SIZE_PHA_CNT-1:0]            hold = '0;
  logic                               busy;
  logic [SIZE_LOST_CNT-1:0]           lost;

  trapez_peak_sampler_if evt ();
  assign evt.event_ready = ready;

  trapez_peak_sampler dut (
    .clk            (clk),
    .reset          (rst_n),
    .shaper_data    (data),
    .enable         (enable),
    .threshold      (thr),
    .flat_top_delay (ftd),
    .holdoff        (hold),
    .evt            (evt),
    .busy           (busy),
    .lost_count     (lost)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   seg_base = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];

  int   n;
  int   d_a[];
  bit   en_a[];
  bit   rd_a[];
  int   bz_a[];
  int   pat[$];

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Monitor: compares every handshake against the scoreboard and checks
  // that a stalled event holds still.
  bit held = 0;
  logic signed [SIZE_SHAPER_DATA-1:0] h_height;
  logic [SIZE_TIMESTAMP-1:0] h_ts;
  logic h_pile;
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (held) begin
        checks++;
        if (!evt.event_valid || evt.event_height != h_height ||
            evt.event_timestamp != h_ts || (h_pile && !evt.event_pileup)) begin
          errors++;
          $display("FAIL hold_stable: got v=%0b h=%0d ts=%0d p=%0b required v=1 h=%0d ts=%0d p>=%0b",
                   evt.event_valid, evt.event_height, evt.event_timestamp, evt.event_pileup,
                   h_height, h_ts, h_pile);
        end
      end
      if (evt.event_valid && evt.event_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: got h=%0d ts=%0d at cycle %0d, required none",
                   evt.event_height, evt.event_timestamp, cyc - seg_base);
        end else begin
          e = exp_q.pop_front();
          if (evt.event_height != 16'(e.height) || evt.event_timestamp != 32'(e.ts) ||
              evt.event_pileup != e.pile || (cyc - seg_base) != e.cyc) begin
            errors++;
            $display("FAIL event: got h=%0d ts=%0d p=%0b cyc=%0d required h=%0d ts=%0d p=%0b cyc=%0d",
                     evt.event_height, evt.event_timestamp, evt.event_pileup, cyc - seg_base,
                     e.height, e.ts, e.pile, e.cyc);
          end else begin
            $display("event ok: h=%0d ts=%0d p=%0b cyc=%0d", e.height, e.ts, e.pile, e.cyc);
          end
        end
      end
      held     = evt.event_valid && !evt.event_ready;
      h_height = evt.event_height;
      h_ts     = evt.event_timestamp;
      h_pile   = evt.event_pileup;
    end else begin
      held = 0;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic init_seg(input int len, input int base);
    n    = len + 30;
    d_a  = new[n];
    en_a = new[n];
    rd_a = new[n];
    bz_a = new[n];
    for (int k = 0; k < n; k++) begin
      d_a[k]  = (k < len) ? base : -1000;
      en_a[k] = 1'b1;
      rd_a[k] = 1'b1;
      bz_a[k] = -1;
    end
  endtask

  task automatic put(input int at);
    foreach (pat[j]) d_a[at + j] = pat[j];
  endtask

  // Pulse-level reference: find a crossing, take the max over the window
  // samples, scan the tail, skip the holdoff, then decide load/drop against
  // the consumer's ready pattern.
  task automatic model(input int f, input int h, input int t, output int lost_exp);
    int c, nxt, L, tcur, acc, mx, prev_acc;
    bit abort, have_prev;
    int piles[$];
    exp_t e;
    c = 0; lost_exp = 0; have_prev = 0; prev_acc = 0;
    while (c < n) begin
      if (!en_a[c] || d_a[c] <= t) begin
        c++;
        continue;
      end
      mx = d_a[c]; abort = 0; nxt = n;
      for (int k = 1; k <= f; k++) begin
        if (c + k >= n || !en_a[c + k]) begin
          abort = 1; nxt = c + k + 1;
          break;
        end
        if (d_a[c + k] > mx) mx = d_a[c + k];
      end
      if (abort) begin
        c = nxt;
        continue;
      end
      L = c + f + 1;
      piles.delete();
      tcur = L; nxt = n;
      while (tcur < n) begin
        if (!en_a[tcur]) begin
          nxt = tcur + 1;
          break;
        end
        if (d_a[tcur] > mx) piles.push_back(tcur);
        if (d_a[tcur] <= t) begin
          nxt = tcur + 1 + h;
          for (int q = tcur + 1; q <= tcur + h && q < n; q++) begin
            if (!en_a[q]) begin
              nxt = q + 1;
              break;
            end
          end
          break;
        end
        tcur++;
      end
      if (!have_prev || prev_acc <= L) begin
        acc = L + 1;
        while (acc < n && !rd_a[acc]) acc++;
        e.height = mx; e.ts = c; e.cyc = acc; e.pile = 0;
        foreach (piles[j]) if (piles[j] < acc) e.pile = 1;
        exp_q.push_back(e);
        have_prev = 1; prev_acc = acc;
      end else begin
        lost_exp++;
      end
      c = nxt;
    end
  endtask

  task automatic run_seg(input string name, input int f, input int h, input int t);
    int el;
    model(f, h, t, el);
    @(posedge clk); #1;
    rst_n = 1'b0; enable = 1'b0; ready = 1'b0; data = '0;
    ftd = SIZE_PHA_CNT'(f); hold = SIZE_PHA_CNT'(h); thr = 16'(t);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seg_base = cyc;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      data = 16'(d_a[k]); enable = en_a[k]; ready = rd_a[k];
      if (bz_a[k] >= 0) chk({name, " busy"}, int'(busy), bz_a[k]);
    end
    @(negedge clk); #1;
    chk({name, " lost_count"}, int'(lost), el);
    chk({name, " pending_events"}, exp_q.size(), 0);
    exp_q.delete();
    $display("segment %s: ftd=%0d holdoff=%0d thr=%0d lost=%0d", name, f, h, t, el);
  endtask

  task automatic reset_in_tail();
    init_seg(60, 0);
    pat = '{150, 300, 320, 310, 90, 0}; put(11);
    pat = '{200, 500, 400, 300};        put(30);
    for (int k = 34; k < 60; k++) d_a[k] = 250;
    @(posedge clk); #1;
    rst_n = 1'b0; enable = 1'b0; ready = 1'b0; data = '0;
    ftd = 12'd3; hold = 12'd2; thr = 16'sd100;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seg_base = cyc;
    for (int k = 0; k < 41; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      data = 16'(d_a[k]); enable = 1'b1; ready = 1'b0;
      if (k == 38) begin
        chk("rst_tail pre valid", int'(evt.event_valid), 1);
        chk("rst_tail pre height", int'(evt.event_height), 320);
        chk("rst_tail pre lost", int'(lost), 1);
        chk("rst_tail pre busy", int'(busy), 1);
      end
      if (k == 40) rst_n = 1'b0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1; enable = 1'b0;
    chk("rst_tail valid", int'(evt.event_valid), 0);
    chk("rst_tail height", int'(evt.event_height), 0);
    chk("rst_tail timestamp", int'(evt.event_timestamp), 0);
    chk("rst_tail pileup", int'(evt.event_pileup), 0);
    chk("rst_tail busy", int'(busy), 0);
    chk("rst_tail lost", int'(lost), 0);
    $display("segment reset_in_tail done");
  endtask

  initial begin
    int f, h, t;

    // Basic pulse, immediate accept.
    init_seg(40, 0);
    pat = '{50, 150, 300, 320, 310, 90, 0}; put(10);
    bz_a[11] = 0; bz_a[12] = 1; bz_a[18] = 0;
    run_seg("basic", 3, 2, 100);

    // Late pile-up folded into the unaccepted event.
    init_seg(40, 0);
    pat = '{50, 150, 300, 320, 310, 250, 400, 90, 0}; put(10);
    for (int k = 0; k < 20; k++) rd_a[k] = 1'b0;
    run_seg("pileup", 3, 2, 100);

    // Full output register: second pulse dropped.
    init_seg(70, 0);
    pat = '{50, 150, 300, 320, 310, 90, 0}; put(10);
    pat = '{200, 500, 400, 300, 90, 0};     put(30);
    for (int k = 0; k < 60; k++) rd_a[k] = 1'b0;
    run_seg("drop", 3, 2, 100);

    // Enable removed mid-window.
    init_seg(40, 0);
    pat = '{150, 300, 320, 310, 90, 0}; put(11);
    for (int k = 13; k < 17; k++) en_a[k] = 1'b0;
    bz_a[12] = 1; bz_a[14] = 0;
    run_seg("abort", 3, 2, 100);

    // Crossing ignored during holdoff, honoured right after.
    init_seg(40, 0);
    pat = '{200, 250, 50, 0, 300, 50, 0, 260, 270, 40}; put(10);
    bz_a[16] = 1; bz_a[17] = 0;
    run_seg("holdoff", 1, 4, 100);

    // Signed threshold, including the equal-to-threshold non-crossing.
    init_seg(40, -100);
    pat = '{-40, -30, -45, -60}; put(10);
    d_a[20] = -50;
    d_a[30] = -49;
    run_seg("signed", 2, 1, -50);

    for (int s = 0; s < 6; s++) begin
      init_seg(150, 0);
      for (int k = 0; k < 150; k++) begin
        d_a[k]  = int'($urandom_range(0, 400)) - 150;
        en_a[k] = ($urandom_range(0, 15) != 0);
        rd_a[k] = ($urandom_range(0, 1) == 1);
      end
      f = int'($urandom_range(0, 5));
      h = int'($urandom_range(0, 5));
      t = int'($urandom_range(0, 200)) - 50;
      run_seg($sformatf("rand%0d", s), f, h, t);
    end

    reset_in_tail();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
